// File: rtl/request_unit.sv
// request_unit: sequences instruction fetch and data access requests for a
// multi-cycle core, emits the PC-advance pulse and counts retired instructions.
// Ports:
//   CLK, nRST            - clock (rising edge), asynchronous active-low reset
//   ihit, dhit           - instruction / data memory completion strobes
//   dREN, dWEN, halt     - decoded controls of the instruction being fetched
//   imemREN              - instruction fetch request
//   dmemREN, dmemWEN     - data read / write requests (registered access type)
//   pcEN                 - one-cycle retire pulse
//   halted               - sticky halt indication
//   inst_count           - 32-bit retired-instruction counter (wraps)
module request_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        halt,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        pcEN,
  output logic        halted,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rd;
  logic        r_wr;
  logic        r_halted;
  logic [31:0] r_inst_count;
  logic        w_latch;

  // State and datapath registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_halted     <= 1'b0;
      r_inst_count <= 32'd0;
    end else begin
      r_state <= w_next;
      // Capture access type as the memory instruction arrives; a simultaneous
      // read and write request resolves to a write.
      if (w_latch) begin
        r_rd <= dREN & ~dWEN;
        r_wr <= dWEN;
      end
      if (w_next == HALT) begin
        r_halted <= 1'b1;
      end
      if (pcEN) begin
        r_inst_count <= r_inst_count + 32'd1;
      end
    end
  end

  // Next-state and outputs
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    pcEN    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_next = FETCH;
      end
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (halt) begin
            w_next = HALT;
          end else if (dREN | dWEN) begin
            w_next  = DATA;
            w_latch = 1'b1;
          end else begin
            pcEN = 1'b1;
          end
        end
      end
      DATA: begin
        // Requests come only from the latched type so they stay stable
        // regardless of what the decoder shows during the wait.
        dmemREN = r_rd;
        dmemWEN = r_wr;
        if (dhit) begin
          pcEN   = 1'b1;
          w_next = FETCH;
        end
      end
      HALT: begin
        w_next = HALT;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign halted     = r_halted;
  assign inst_count = r_inst_count;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: inputs change 1ns after the rising edge,
// outputs are checked 2ns after the rising edge.
module tb_request_unit;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic        dhit;
  logic        dREN;
  logic        dWEN;
  logic        halt;
  logic        imemREN;
  logic        dmemREN;
  logic        dmemWEN;
  logic        pcEN;
  logic        halted;
  logic [31:0] inst_count;

  int n_chk;
  int n_bad;

  request_unit dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ihit       (ihit),
    .dhit       (dhit),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .halt       (halt),
    .imemREN    (imemREN),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .pcEN       (pcEN),
    .halted     (halted),
    .inst_count (inst_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check all four request/pulse outputs at once
  task automatic chk_out(input string tag, input logic i, input logic r,
                         input logic w, input logic p);
    chk({tag, ".imemREN"}, {31'd0, imemREN}, {31'd0, i});
    chk({tag, ".dmemREN"}, {31'd0, dmemREN}, {31'd0, r});
    chk({tag, ".dmemWEN"}, {31'd0, dmemWEN}, {31'd0, w});
    chk({tag, ".pcEN"},    {31'd0, pcEN},    {31'd0, p});
  endtask

  // Advance to 1ns after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ih, input logic dh, input logic rd,
                       input logic wr, input logic hl);
    ihit = ih; dhit = dh; dREN = rd; dWEN = wr; halt = hl;
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) step();
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk_out("rel_idle", 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk_out("rel_fetch", 1, 0, 0, 0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    nRST  = 1'b0;
    ihit  = 0; dhit = 0; dREN = 0; dWEN = 0; halt = 0;

    // Reset held with clock running, noisy inputs ignored
    #2;
    drive(1, 1, 1, 1, 0);
    repeat (3) step();
    chk_out("rst", 0, 0, 0, 0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.count", inst_count, 32'd0);

    do_reset();

    // ihit held low: stay in FETCH
    for (int k = 0; k < 5; k++) begin
      step();
      drive(0, 1, 0, 0, 0);
      chk_out("wait_ihit", 1, 0, 0, 0);
      chk("wait_ihit.count", inst_count, 32'd0);
    end

    // Three ALU instructions back to back
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0);
      chk_out("alu", 1, 0, 0, 1);
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("alu.count", inst_count, 32'd3);
    chk_out("alu_after", 1, 0, 0, 0);

    // Load with three wait cycles
    drive(1, 0, 1, 0, 0);
    chk_out("ld_issue", 1, 0, 0, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      // decoder inputs and a stray ihit must not disturb the data phase
      drive(1, 0, 0, (k == 1), 0);
      chk_out("ld_wait", 0, 1, 0, 0);
      step();
    end
    drive(0, 1, 0, 0, 0);
    chk_out("ld_dhit", 0, 1, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    chk_out("ld_done", 1, 0, 0, 0);
    chk("ld.count", inst_count, 32'd4);

    // Store with dREN and dWEN both set: write only
    drive(1, 0, 1, 1, 0);
    chk_out("st_issue", 1, 0, 0, 0);
    step();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 0, 0);
      chk_out("st_wait", 0, 0, 1, 0);
      step();
    end
    drive(0, 1, 0, 0, 0);
    chk_out("st_dhit", 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0);
    chk_out("st_done", 1, 0, 0, 0);
    chk("st.count", inst_count, 32'd5);

    // Asynchronous reset in the middle of a store
    drive(1, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk_out("ab_data", 0, 0, 1, 0);
    nRST = 1'b0;
    #1;
    chk_out("ab_rst", 0, 0, 0, 0);
    chk("ab_rst.count", inst_count, 32'd0);
    do_reset();

    // Two instructions, then halt
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 0);
      chk_out("pre_halt", 1, 0, 0, 1);
      step();
    end
    drive(1, 0, 1, 0, 1);
    chk_out("halt_fetch", 1, 0, 0, 0);
    chk("halt_fetch.halted", {31'd0, halted}, 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, (k == 0), (k == 1), (k == 2));
      chk_out("halted", 0, 0, 0, 0);
      chk("halted.flag", {31'd0, halted}, 32'd1);
      chk("halted.count", inst_count, 32'd2);
      step();
    end

    // Reset out of HALT clears the flag immediately
    #2;
    nRST = 1'b0;
    #1;
    chk("halt_rst.flag", {31'd0, halted}, 32'd0);
    chk("halt_rst.count", inst_count, 32'd0);
    do_reset();
    drive(1, 0, 0, 0, 0);
    chk_out("post_rst_alu", 1, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    chk("post_rst.count", inst_count, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global timeout so the bench always ends
  initial begin
    #20000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 SHALL have port CLK, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port nRST, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port ihit, input, 1, instruction memory returned valid word this cycle.
REQ-004 SHALL have port dhit, input, 1, data memory access completed this cycle.
REQ-005 SHALL have port dREN, input, 1, decoded load request for current instruction.
REQ-006 SHALL have port dWEN, input, 1, decoded store request for current instruction.
REQ-007 SHALL have port halt, input, 1, decoded halt for current instruction.
REQ-008 SHALL have port imemREN, output, 1, instruction fetch request.
REQ-009 SHALL have port dmemREN, output, 1, data read request.
REQ-010 SHALL have port dmemWEN, output, 1, data write request.
REQ-011 SHALL have port pcEN, output, 1, one-cycle pulse: PC advances and instruction retires.
REQ-012 SHALL have port halted, output, 1, sticky halt indication.
REQ-013 SHALL have port inst_count, output, 32, retired-instruction counter.

Function
REQ-014 SHALL implement a 4-state FSM: IDLE, FETCH, DATA, HALT.
REQ-015 IDLE: all request outputs 0, pcEN 0; SHALL move to FETCH on next edge unconditionally.
REQ-016 FETCH: imemREN 1, dmemREN/dmemWEN 0.
REQ-017 FETCH with ihit=0: SHALL remain in FETCH, pcEN 0.
REQ-018 FETCH with ihit=1 and halt=1: SHALL go to HALT, pcEN 0, no data request issued, dREN/dWEN ignored.
REQ-019 FETCH with ihit=1, halt=0, dREN|dWEN=1: SHALL go to DATA, pcEN 0, and latch access type (rd_q=dREN&~dWEN, wr_q=dWEN).
REQ-020 FETCH with ihit=1, halt=0, dREN=dWEN=0: SHALL stay in FETCH with pcEN=1 that same cycle (combinational on ihit).
REQ-021 DATA: imemREN 0, dmemREN=rd_q, dmemWEN=wr_q, both driven from registered state only (no combinational path from dREN/dWEN).
REQ-022 DATA with dhit=0: SHALL remain in DATA holding requests stable.
REQ-023 DATA with dhit=1: SHALL assert pcEN=1 that cycle and go to FETCH; dmemREN/dmemWEN drop to 0 on next cycle.
REQ-024 dREN=dWEN=1 simultaneously SHALL be treated as write only (dmemWEN=1, dmemREN=0).
REQ-025 ihit while in DATA and dhit while in FETCH/IDLE/HALT SHALL be ignored.
REQ-026 HALT: all requests 0, pcEN 0, halted 1; absorbing until nRST asserted.
REQ-027 halted SHALL be registered and go 1 on the edge entering HALT.
REQ-028 dmemREN and dmemWEN SHALL never both be 1; imemREN SHALL never be 1 together with either.
REQ-029 inst_count SHALL increment by 1 on each edge where pcEN=1, wrapping 0xFFFFFFFF -> 0x00000000; halt instruction not counted.
REQ-030 pcEN SHALL be 1 for at most one cycle per retired instruction.

Reset
REQ-031 While nRST=0: state IDLE, rd_q=wr_q=0, halted 0, inst_count 0, imemREN/dmemREN/dmemWEN/pcEN 0, regardless of CLK.
REQ-032 nRST asserted mid-DATA or in HALT SHALL abort immediately (asynchronously) to reset values; no pcEN issued for the aborted instruction.
REQ-033 After nRST deasserts, first edge SHALL go IDLE -> FETCH; imemREN 1 from the following cycle.

Verification
REQ-034 Reset release, ihit held 0 for 5 cycles -> imemREN 1 continuously, pcEN 0, inst_count 0.
REQ-035 Three ALU instructions, ihit=1 each on consecutive FETCH cycles -> three pcEN pulses, inst_count 3, dmemREN/dmemWEN stay 0.
REQ-036 Load: ihit with dREN=1, dhit after 3 wait cycles -> dmemREN 1 for 4 cycles, imemREN 0 throughout, single pcEN on dhit cycle, then FETCH.
REQ-037 Store with dREN=dWEN=1 -> dmemWEN 1, dmemREN 0 until dhit; pcEN once.
REQ-038 halt with ihit after 2 retired instructions -> halted 1 next edge, all requests 0 forever, inst_count stays 2 despite further ihit/dhit.
REQ-039 nRST pulsed low mid-DATA (dmemWEN=1) -> dmemWEN 0 immediately, inst_count 0, restart IDLE -> FETCH.
